// File: rtl/spi_wb_bridge_if.sv
// Classic single-beat Wishbone link between the SPI debug bridge (master) and the interconnect (slave).
interface spi_wb_bridge_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic        ack;
   logic        err;

   modport master (output adr, dat_w, sel, we, cyc, stb, cti, input dat_r, ack, err);
   modport slave  (input adr, dat_w, sel, we, cyc, stb, cti, output dat_r, ack, err);
endinterface

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave giving a debug host single-beat Wishbone access; SPI pins are oversampled in the
// Wishbone clock domain, so SCLK must stay at or below wb_clk_i/8.
module spi_wb_bridge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned WB_TIMEOUT  = 32,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            spi_cs_n_i,
   input  logic            spi_sclk_i,
   input  logic            spi_mosi_i,
   output logic            spi_miso_o,
   output logic            spi_miso_oe_o,
   spi_wb_bridge_if.master wbm
);
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_STATUS, S_IGNORE
   } state_e;

   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam logic [7:0] CMD_STATUS = 8'h05;
   localparam int unsigned TMR_W     = $clog2(WB_TIMEOUT + 1);

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             byte_cnt_q, byte_cnt_d;
   logic [7:0]             rx_q, rx_d;
   logic [31:0]            tx_q, tx_d;
   logic                   shift_pend_q, shift_pend_d;
   logic                   cmd_wr_q, cmd_wr_d;
   logic [31:0]            adr_q, adr_d;
   logic [31:0]            wdat_q, wdat_d;
   logic [31:0]            rdat_q, rdat_d;
   logic                   cyc_q, cyc_d;
   logic                   we_q, we_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   err_q, err_d;

   logic       cs_act, sclk_s, mosi_s, sclk_rise, sclk_fall, byte_done;
   logic [7:0] rx_next;
   logic       adr_shift, dat_shift, launch_rd, launch_wr;
   logic       load_status, load_rdata, status_done, busy_reject, err_set;

   assign cs_act    = ~cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = cs_act &  sclk_s & ~sclk_prev_q;
   assign sclk_fall = cs_act & ~sclk_s &  sclk_prev_q;
   assign rx_next   = {rx_q[6:0], mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (!cs_act) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:  state_d = S_CMD;
            S_CMD: if (byte_done) begin
               if ((rx_next == CMD_WRITE || rx_next == CMD_READ) && !cyc_q) state_d = S_ADDR;
               else if (rx_next == CMD_STATUS)                               state_d = S_STATUS;
               else                                                          state_d = S_IGNORE;
            end
            S_ADDR:  if (byte_done && byte_cnt_q == 3'd3) state_d = cmd_wr_q ? S_WDATA : S_DUMMY;
            S_WDATA: if (byte_done && byte_cnt_q == 3'd3) state_d = S_IGNORE;
            S_DUMMY: if (byte_done) state_d = S_RDATA;
            default: ;
         endcase
      end
   end

   always_comb begin
      adr_shift   = 1'b0;
      dat_shift   = 1'b0;
      launch_rd   = 1'b0;
      launch_wr   = 1'b0;
      load_status = 1'b0;
      load_rdata  = 1'b0;
      status_done = 1'b0;
      busy_reject = 1'b0;
      if (byte_done) begin
         unique case (state_q)
            S_CMD: begin
               load_status = (rx_next == CMD_STATUS);
               busy_reject = (rx_next == CMD_WRITE || rx_next == CMD_READ) && cyc_q;
            end
            S_ADDR: begin
               adr_shift = 1'b1;
               launch_rd = (byte_cnt_q == 3'd3) && !cmd_wr_q;
            end
            S_WDATA: begin
               dat_shift = 1'b1;
               launch_wr = (byte_cnt_q == 3'd3);
            end
            S_DUMMY:  load_rdata  = 1'b1;
            S_STATUS: status_done = (byte_cnt_q == 3'd0);
            default: ;
         endcase
      end
   end

   // SPI datapath: byte assembly and the MISO shifter, all flushed while CS is inactive.
   always_comb begin
      cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_d  = sclk_s;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      shift_pend_d = shift_pend_q;
      cmd_wr_d     = cmd_wr_q;
      if (!cs_act) begin
         bit_cnt_d    = 3'd0;
         byte_cnt_d   = 3'd0;
         rx_d         = 8'h00;
         tx_d         = 32'h0;
         shift_pend_d = 1'b0;
      end else begin
         if (sclk_rise) begin
            bit_cnt_d    = bit_cnt_q + 3'd1;
            rx_d         = rx_next;
            // Only bits clocked out in a data phase advance the shifter, so the first bit survives
            // the falling edge that closes the command or dummy byte.
            shift_pend_d = (state_q == S_RDATA) || (state_q == S_STATUS);
         end else if (sclk_fall && shift_pend_q) begin
            tx_d         = {tx_q[30:0], 1'b0};
            shift_pend_d = 1'b0;
         end
         if (state_d != state_q)                       byte_cnt_d = 3'd0;
         else if (byte_done && byte_cnt_q != 3'd7)     byte_cnt_d = byte_cnt_q + 3'd1;
         if (byte_done && state_q == S_CMD)            cmd_wr_d   = (rx_next == CMD_WRITE);
         if (load_status)                              tx_d = {6'b0, err_q, cyc_q, 24'h0};
         else if (load_rdata)                          tx_d = rdat_q;
      end
   end

   // Bus engine runs on its own once launched, so a CS rise never cuts a cycle short.
   always_comb begin
      adr_d   = adr_shift ? {adr_q[23:0], rx_next} : adr_q;
      wdat_d  = dat_shift ? {wdat_q[23:0], rx_next} : wdat_q;
      rdat_d  = rdat_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      tmr_d   = tmr_q;
      err_set = busy_reject;
      if (cyc_q) begin
         tmr_d = tmr_q + 1'b1;
         if (wbm.ack) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            if (!we_q) rdat_d = wbm.dat_r;
         end else if (wbm.err || tmr_q == TMR_W'(WB_TIMEOUT - 1)) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            err_set = 1'b1;
            if (!we_q) rdat_d = ERR_DATA;
         end
      end else if (launch_wr || launch_rd) begin
         cyc_d = 1'b1;
         we_d  = launch_wr;
         tmr_d = '0;
      end
      err_d = err_set ? 1'b1 : (status_done ? 1'b0 : err_q);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cs_sync_q    <= '1;
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 3'd0;
         rx_q         <= 8'h00;
         tx_q         <= 32'h0;
         shift_pend_q <= 1'b0;
         cmd_wr_q     <= 1'b0;
         adr_q        <= 32'h0;
         wdat_q       <= 32'h0;
         rdat_q       <= 32'h0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         tmr_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         cs_sync_q    <= cs_sync_d;
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         shift_pend_q <= shift_pend_d;
         cmd_wr_q     <= cmd_wr_d;
         adr_q        <= adr_d;
         wdat_q       <= wdat_d;
         rdat_q       <= rdat_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         tmr_q        <= tmr_d;
         err_q        <= err_d;
      end
   end

   assign spi_miso_o    = tx_q[31];
   assign spi_miso_oe_o = cs_act;
   assign wbm.adr       = adr_q;
   assign wbm.dat_w     = wdat_q;
   assign wbm.sel       = 4'hF;
   assign wbm.we        = we_q;
   assign wbm.cyc       = cyc_q;
   assign wbm.stb       = cyc_q;
   assign wbm.cti       = 3'b000;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge: a bit-banged SPI host plus a configurable Wishbone slave/monitor.
module tb_spi_wb_bridge;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, cs_n, sclk, mosi, miso, miso_oe;
   spi_wb_bridge_if wb();

   spi_wb_bridge dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .spi_cs_n_i    (cs_n),
      .spi_sclk_i    (sclk),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oe_o (miso_oe),
      .wbm           (wb)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Slave behaviour: 0 = ack after slv_lat cycles, 1 = never answer, 2 = err after slv_lat cycles.
   int          slv_mode;
   int          slv_lat;
   logic [31:0] slv_rdata;
   assign wb.dat_r = slv_rdata;

   int          cyc_count = 0;
   int          cyc_len   = 0;
   bit          cyc_prev  = 1'b0;
   bit          resp_done = 1'b0;
   logic [31:0] rec_adr, rec_dat;
   logic [3:0]  rec_sel;
   logic        rec_we;

   always @(negedge clk) begin
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (wb.cyc) begin
         if (!cyc_prev) begin
            cyc_count++;
            rec_adr = wb.adr;
            rec_dat = wb.dat_w;
            rec_sel = wb.sel;
            rec_we  = wb.we;
            cyc_len = 0;
         end
         cyc_len++;
         if (wb.stb && !resp_done && cyc_len == slv_lat) begin
            if (slv_mode == 0) begin wb.ack = 1'b1; resp_done = 1'b1; end
            if (slv_mode == 2) begin wb.err = 1'b1; resp_done = 1'b1; end
         end
      end else begin
         resp_done = 1'b0;
      end
      cyc_prev = wb.cyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #50;
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #100;
      cs_n = 1'b1;
      mosi = 1'b0;
      #200;
   endtask

   task automatic spi_status(output logic [7:0] st);
      logic [7:0] d;
      cs_low();
      spi_byte(8'h05, d);
      spi_byte(8'h00, st);
      cs_high();
   endtask

   task automatic spi_write(input logic [31:0] adr, input logic [31:0] dat, input int n_dat);
      logic [7:0] d;
      cs_low();
      spi_byte(8'h02, d);
      for (int i = 3; i >= 0; i--) spi_byte(adr[8*i +: 8], d);
      for (int i = 3; i >= 4 - n_dat; i--) spi_byte(dat[8*i +: 8], d);
      cs_high();
   endtask

   task automatic spi_read(input logic [31:0] adr, output logic [31:0] rd, output logic [7:0] extra);
      logic [7:0] d;
      cs_low();
      spi_byte(8'h03, d);
      for (int i = 3; i >= 0; i--) spi_byte(adr[8*i +: 8], d);
      spi_byte(8'h00, d);
      for (int i = 3; i >= 0; i--) begin
         spi_byte(8'h00, d);
         rd[8*i +: 8] = d;
      end
      spi_byte(8'h00, extra);
      cs_high();
   endtask

   initial begin
      logic [7:0]  st, b;
      logic [31:0] rd;
      int          snap;

      rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      slv_mode = 0; slv_lat = 3; slv_rdata = 32'h0;
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);

      // Reset state with CS high
      check("rst_cyc", wb.cyc, 1'b0);
      check("rst_stb", wb.stb, 1'b0);
      check("rst_we", wb.we, 1'b0);
      check("rst_adr", wb.adr, 32'h0);
      check("rst_dat", wb.dat_w, 32'h0);
      check("rst_sel", wb.sel, 4'hF);
      check("rst_cti", wb.cti, 3'b000);
      check("rst_oe", miso_oe, 1'b0);
      check("rst_miso", miso, 1'b0);
      spi_status(st);
      check("rst_status", st, 8'h00);

      // Full write, slave acks on the third cycle
      snap = cyc_count;
      spi_write(32'h1000_0000, 32'hCAFE_F00D, 4);
      check("wr_count", cyc_count - snap, 1);
      check("wr_adr", rec_adr, 32'h1000_0000);
      check("wr_dat", rec_dat, 32'hCAFE_F00D);
      check("wr_sel", rec_sel, 4'hF);
      check("wr_we", rec_we, 1'b1);
      check("wr_len", cyc_len, 3);
      check("wr_cyc_idle", wb.cyc, 1'b0);
      spi_status(st);
      check("wr_status", st, 8'h00);

      // Read with data returned after dummy byte, then zero padding
      slv_rdata = 32'h1234_5678;
      snap = cyc_count;
      spi_read(32'h0000_0004, rd, b);
      check("rd_data", rd, 32'h1234_5678);
      check("rd_pad", b, 8'h00);
      check("rd_count", cyc_count - snap, 1);
      check("rd_adr", rec_adr, 32'h0000_0004);
      check("rd_we", rec_we, 1'b0);

      // Slave never answers: timeout, error data, sticky error cleared by status read
      slv_mode = 1;
      spi_read(32'h0000_0020, rd, b);
      check("to_len", cyc_len, 32);
      check("to_data", rd, 32'hDEAD_BEEF);
      check("to_pad", b, 8'h00);
      spi_status(st);
      check("to_status1", st, 8'h02);
      spi_status(st);
      check("to_status2", st, 8'h00);

      // Write aborted after two data bytes, then a normal read of the same address
      slv_mode = 0; slv_lat = 2; slv_rdata = 32'hA5A5_5A5A;
      snap = cyc_count;
      spi_write(32'h3000_0000, 32'h1122_3344, 2);
      check("abort_count", cyc_count - snap, 0);
      spi_read(32'h3000_0000, rd, b);
      check("abort_rd_data", rd, 32'hA5A5_5A5A);
      check("abort_rd_count", cyc_count - snap, 1);
      check("abort_rd_adr", rec_adr, 32'h3000_0000);

      // Unknown command: no bus activity, MISO held low
      snap = cyc_count;
      cs_low();
      check("ign_oe", miso_oe, 1'b1);
      spi_byte(8'h7E, b);
      check("ign_cmd_miso", b, 8'h00);
      for (int i = 0; i < 6; i++) begin
         spi_byte(8'hFF, b);
         check("ign_miso", b, 8'h00);
      end
      cs_high();
      check("ign_count", cyc_count - snap, 0);
      check("ign_oe_off", miso_oe, 1'b0);

      // Bus error on a write sets sticky error
      slv_mode = 2; slv_lat = 2;
      spi_write(32'h4000_0000, 32'h0BAD_F00D, 4);
      check("err_len", cyc_len, 2);
      spi_status(st);
      check("err_status1", st, 8'h02);
      spi_status(st);
      check("err_status2", st, 8'h00);

      // Reset while a cycle is outstanding drops cyc/stb on the next edge
      slv_mode = 1;
      cs_low();
      spi_byte(8'h02, b);
      for (int i = 0; i < 8; i++) spi_byte(8'h5A, b);
      #50;
      check("mid_cyc_high", wb.cyc, 1'b1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_cyc", wb.cyc, 1'b0);
      check("mid_rst_stb", wb.stb, 1'b0);
      @(negedge clk) rst = 1'b0;
      cs_high();
      spi_status(st);
      check("mid_rst_status", st, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
